// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx : parallel-to-serial frame transmitter.
//
// Accepts a WIDTH-bit word through a load/ready handshake and sends it on a
// single line, one bit per clock:
//   - a start bit of 1;
//   - the data bits, MSB first;
//   - an optional even-parity bit;
//   - STOP_BITS cycles of 0.
// The idle level of the line is 0.
//
// Build option:
//   PISO_PARITY_EN - when defined, the PARITY state is compiled in and an
//                    even-parity bit (XOR of the data) follows the data bits.
//
// Parameters:
//   WIDTH      data word width (>= 2)
//   STOP_BITS  stop-bit cycles per frame (>= 1)
//
// Ports:
//   clk      in   sole clock, rising edge
//   reset    in   asynchronous, active-high reset
//   data_in  in   word to send, sampled on accept (load && ready)
//   load     in   a word is offered on data_in
//   ready    out  a word can be accepted this cycle
//   out      out  registered serial line
//   busy     out  a frame is in progress
//   done     out  one-cycle pulse during the final stop-bit cycle
// -----------------------------------------------------------------------------
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int BIT_CNT_W  = $clog2(WIDTH);
  localparam int STOP_CNT_W = $clog2(STOP_BITS + 1);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(WIDTH - 1);
  localparam logic [STOP_CNT_W-1:0] LAST_STOP = STOP_CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef PISO_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [WIDTH-1:0]        r_shift;
  logic [BIT_CNT_W-1:0]    r_bit_cnt;
  logic [STOP_CNT_W-1:0]   r_stop_cnt;
  logic                    r_out;
  logic                    w_out_next;
  logic                    w_last_stop;
  logic                    w_accept;
`ifdef PISO_PARITY_EN
  logic                    r_parity;
`endif

  // Final stop cycle: the only cycle besides IDLE that can take a new word,
  // which is what gives back-to-back frames with no idle gap.
  assign w_last_stop = (r_state == S_STOP) && (r_stop_cnt == LAST_STOP);
  assign w_accept    = load && ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours; blocking here would create ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps every path assigned, so no
  // latch is inferred even if a case branch is later edited.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (load) w_next_state = S_START;
      S_START: w_next_state = S_DATA;
      S_DATA: begin
        if (r_bit_cnt == LAST_BIT) begin
`ifdef PISO_PARITY_EN
          w_next_state = S_PARITY;
`else
          w_next_state = S_STOP;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: w_next_state = S_STOP;
`endif
      S_STOP: begin
        if (w_last_stop) w_next_state = load ? S_START : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so there is no
  // combinational path from load to ready.
  // ---------------------------------------------------------------------------
  always_comb begin
    ready = (r_state == S_IDLE) || w_last_stop;
    busy  = (r_state != S_IDLE);
    done  = w_last_stop;
    out   = r_out;
  end

  // Value the line takes after this edge. Leaving START the MSB is already at
  // the top of the shift register; inside DATA the shift happens on the same
  // edge, so the following bit is the one just below the top.
  always_comb begin
    w_out_next = 1'b0;
    case (w_next_state)
      S_START: w_out_next = 1'b1;
      S_DATA:  w_out_next = (r_state == S_START) ? r_shift[WIDTH-1] : r_shift[WIDTH-2];
`ifdef PISO_PARITY_EN
      S_PARITY: w_out_next = r_parity;
`endif
      default: w_out_next = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift register, counters, line register
  // ---------------------------------------------------------------------------
  // NOTE: every register here is a plain flop, so all of them are reset; a
  // reset mid-frame drops the line to 0 at once without sending a stop bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= '0;
      r_out      <= 1'b0;
`ifdef PISO_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_out <= w_out_next;

      if (w_accept) begin
        r_shift  <= data_in;
`ifdef PISO_PARITY_EN
        r_parity <= ^data_in;
`endif
      end else if (r_state == S_DATA) begin
        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      end

      // Counters only advance while staying in their own state, so they are
      // already zero on every entry.
      if ((r_state == S_DATA) && (w_next_state == S_DATA)) r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
      else                                                 r_bit_cnt <= '0;

      if ((r_state == S_STOP) && (w_next_state == S_STOP)) r_stop_cnt <= r_stop_cnt + STOP_CNT_W'(1);
      else                                                 r_stop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_tx : self-checking bench for piso_tx.
// Expected line/handshake values per cycle are built from the word being sent
// and queued when stimulus is driven; each cycle pops one entry and compares
// {out, done, ready, busy}. An empty queue means the line must be idle.
// Define PISO_PARITY_EN for both bench and RTL to cover the parity build.
// -----------------------------------------------------------------------------
module tb_piso_tx;

  localparam int WIDTH     = 4;
  localparam int STOP_BITS = 1;
`ifdef PISO_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L = 1 + WIDTH + P + STOP_BITS;
  // {out, done, ready, busy}
  localparam logic [3:0] IDLE_EXP = 4'b0010;

  logic             clk     = 1'b0;
  logic             reset   = 1'b1;
  logic             load    = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             ready, out, busy, done;

  logic [3:0]       sb[$];
  logic [WIDTH:0]   ser_q;
  int               n_checks = 0;
  int               n_fail   = 0;

  piso_tx #(.WIDTH(WIDTH), .STOP_BITS(STOP_BITS)) dut (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .load    (load),
    .ready   (ready),
    .out     (out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream ser shift register, sharing clk/reset.
  always @(posedge clk or posedge reset) begin
    if (reset) ser_q <= '0;
    else       ser_q <= {ser_q[WIDTH-1:0], out};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Queue the per-cycle expectations of one frame carrying w.
  task automatic push_frame(input logic [WIDTH-1:0] w);
    sb.push_back(4'b1001);
    for (int i = WIDTH - 1; i >= 0; i--) sb.push_back({w[i], 3'b001});
    if (P == 1) sb.push_back({^w, 3'b001});
    for (int s = 0; s < STOP_BITS; s++)
      sb.push_back((s == STOP_BITS - 1) ? 4'b0111 : 4'b0001);
  endtask

  task automatic test_reset();
    logic [3:0] e;
    #2;
    n_checks++;
    if ({out, done, ready, busy} !== IDLE_EXP) begin
      n_fail++;
      $display("FAIL reset_initial: got %b required %b", {out, done, ready, busy}, IDLE_EXP);
    end
    @(negedge clk);
    reset = 1'b0;
    load = 1'b1; data_in = 4'b1011; push_frame(data_in);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      load = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if ({out, done, ready, busy} !== e) begin
        n_fail++;
        $display("FAIL reset_preframe cycle %0d: got %b required %b", c, {out, done, ready, busy}, e);
      end
    end
    // Now in DATA: reset for 10 ns, outputs must go idle before any edge.
    #1 reset = 1'b1;
    #2;
    n_checks++;
    if ({out, done, ready, busy} !== IDLE_EXP) begin
      n_fail++;
      $display("FAIL reset_midframe: got %b required %b", {out, done, ready, busy}, IDLE_EXP);
    end
    sb.delete();
    #8 reset = 1'b0;
    @(negedge clk);
    load = 1'b1; data_in = 4'b1011; push_frame(data_in);
    for (int c = 0; c < L + 2; c++) begin
      @(negedge clk);
      load = 1'b0;
      e = (sb.size() != 0) ? sb.pop_front() : IDLE_EXP;
      n_checks++;
      if ({out, done, ready, busy} !== e) begin
        n_fail++;
        $display("FAIL reset_postframe cycle %0d: got %b required %b", c, {out, done, ready, busy}, e);
      end
    end
  endtask

  task automatic test_frames();
    logic [3:0]       e;
    logic [WIDTH-1:0] words[4];
    words[0] = 4'b1011;
    words[1] = 4'b0011;
    words[2] = 4'hE;
    words[3] = WIDTH'($urandom_range(0, 15));
    for (int k = 0; k < 4; k++) begin
      load = 1'b1; data_in = words[k]; push_frame(words[k]);
      for (int c = 0; c < L + 1; c++) begin
        @(negedge clk);
        load = 1'b0;
        data_in = ~data_in;
        e = (sb.size() != 0) ? sb.pop_front() : IDLE_EXP;
        n_checks++;
        if ({out, done, ready, busy} !== e) begin
          n_fail++;
          $display("FAIL frame word=%b cycle %0d: got %b required %b", words[k], c, {out, done, ready, busy}, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    load = 1'b1; data_in = 4'hA;
    push_frame(4'hA); push_frame(4'h5);
    for (int c = 0; c < 2 * L + 2; c++) begin
      @(negedge clk);
      e = (sb.size() != 0) ? sb.pop_front() : IDLE_EXP;
      n_checks++;
      if ({out, done, ready, busy} !== e) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %b required %b", c, {out, done, ready, busy}, e);
      end
      if (c == L - 1) data_in = 4'h5;
      if (c == L)     load = 1'b0;
    end
  endtask

  task automatic test_ignored_load();
    logic [3:0] e;
    load = 1'b1; data_in = 4'h0; push_frame(4'h0);
    for (int c = 0; c < L + 3; c++) begin
      @(negedge clk);
      e = (sb.size() != 0) ? sb.pop_front() : IDLE_EXP;
      n_checks++;
      if ({out, done, ready, busy} !== e) begin
        n_fail++;
        $display("FAIL ignored_load cycle %0d: got %b required %b", c, {out, done, ready, busy}, e);
      end
      load = (c == 2);
      if (c == 2) data_in = 4'hF;
    end
  endtask

  task automatic test_chain();
    logic [3:0] e;
    load = 1'b1; data_in = 4'b1011; push_frame(4'b1011);
    for (int c = 0; c < L + 1; c++) begin
      @(negedge clk);
      load = 1'b0;
      e = (sb.size() != 0) ? sb.pop_front() : IDLE_EXP;
      n_checks++;
      if ({out, done, ready, busy} !== e) begin
        n_fail++;
        $display("FAIL chain_line cycle %0d: got %b required %b", c, {out, done, ready, busy}, e);
      end
      if (c == WIDTH + 1) begin
        n_checks++;
        if (ser_q !== {1'b1, 4'b1011}) begin
          n_fail++;
          $display("FAIL chain_ser: got %b required %b", ser_q, {1'b1, 4'b1011});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_ignored_load();
    test_chain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
